// File: rtl/poly_mau_wb.sv
// poly_mau_wb: write-back stage behind the polynomial MAU.
// Accepts MAU result pairs (in_o0/in_o1), buffers them in a small FIFO and
// writes each pair to two coefficient RAM banks at consecutive addresses
// starting at base0/base1. A job is launched by start, expects len pairs,
// and ends with a one-cycle done pulse once every pair has been written.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, len          job launch (IDLE only) and pair count 0..2^ADDR_W
//   base0, base1        first write address for bank 0 / bank 1
//   in_valid, in_o0/1   result pair from the MAU
//   hold                stall request back to the MAU issue logic
//   wr_en, wr_ready     write handshake (both banks together)
//   wr_addr0/1, wr_data0/1  write address / data per bank
//   busy, done, err     job status; err is sticky until the next start
module poly_mau_wb #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int INFLIGHT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [ADDR_W-1:0] base0,
  input  logic [ADDR_W-1:0] base1,
  input  logic              in_valid,
  input  logic [23:0]       in_o0,
  input  logic [23:0]       in_o1,
  output logic              hold,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [ADDR_W-1:0] wr_addr1,
  output logic [23:0]       wr_data0,
  output logic [23:0]       wr_data1,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DATA_W   = 24;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int LEN_W    = ADDR_W + 1;
  localparam int HOLD_INT = (FIFO_DEPTH > INFLIGHT) ? (FIFO_DEPTH - INFLIGHT) : 0;
  localparam logic [CNT_W-1:0] HOLD_LVL = CNT_W'(HOLD_INT);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [LEN_W-1:0]  len_r;
  logic [ADDR_W-1:0] base0_r;
  logic [ADDR_W-1:0] base1_r;
  logic [LEN_W-1:0]  acc_cnt;
  logic [LEN_W-1:0]  wr_cnt;
  logic [LEN_W-1:0]  acc_nxt;
  logic [LEN_W-1:0]  wr_cnt_nxt;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  occ;
  logic              err_r;

  logic [DATA_W-1:0] fifo_o0_p1 [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_o1_p1 [FIFO_DEPTH];

  logic start_ok;
  logic fifo_empty;
  logic fifo_full;
  logic room;
  logic push;
  logic pop;
  logic drop;

  assign start_ok   = (state == S_IDLE) && start;
  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == FULL_LVL);
  assign pop        = wr_en && wr_ready;
  // Pairs are only wanted while the job still owes results.
  assign room       = (state == S_RUN) && (acc_cnt < len_r);
  // A full FIFO can still take a pair when the head leaves in the same cycle.
  assign push       = in_valid && room && (!fifo_full || pop);
  assign drop       = in_valid && !push;
  assign acc_nxt    = acc_cnt + LEN_W'(push);
  assign wr_cnt_nxt = wr_cnt + LEN_W'(pop);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = (len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (acc_nxt == len_r) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (wr_cnt_nxt == len_r) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs. hold looks only at registered occupancy so the MAU sees a
  // clean, glitch-free stall level.
  always_comb begin
    busy  = (state == S_RUN) || (state == S_DRAIN);
    done  = (state == S_DONE);
    hold  = (state != S_RUN) || (occ >= HOLD_LVL);
    wr_en = busy && !fifo_empty;
  end

  // Job control: latched job parameters, counters, FIFO pointers, error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r   <= '0;
      base0_r <= '0;
      base1_r <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ     <= '0;
      err_r   <= 1'b0;
    end else if (start_ok) begin
      len_r   <= len;
      base0_r <= base0;
      base1_r <= base1;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ     <= '0;
      err_r   <= 1'b0;
    end else begin
      acc_cnt <= acc_nxt;
      wr_cnt  <= wr_cnt_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ     <= occ + CNT_W'(push) - CNT_W'(pop);
      if (drop) err_r <= 1'b1;
    end
  end

  // p0 -> p1: result pair captured into FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_o0_p1[wr_ptr] <= in_o0;
      fifo_o1_p1[wr_ptr] <= in_o1;
    end
  end

  // p1 -> RAM: head of FIFO presented to both banks; zero when idle so the
  // uninitialised storage never reaches the bus.
  assign wr_data0 = wr_en ? fifo_o0_p1[rd_ptr] : '0;
  assign wr_data1 = wr_en ? fifo_o1_p1[rd_ptr] : '0;
  assign wr_addr0 = base0_r + wr_cnt[ADDR_W-1:0];
  assign wr_addr1 = base1_r + wr_cnt[ADDR_W-1:0];
  assign err      = err_r;

endmodule

// File: tb/tb_poly_mau_wb.sv
// Testbench for poly_mau_wb: directed jobs; expected writes are queued as
// pairs are issued and a monitor compares every write the DUT performs.
module tb_poly_mau_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  len;
  logic [7:0]  base0, base1;
  logic        in_valid;
  logic [23:0] in_o0, in_o1;
  logic        hold, wr_en, wr_ready;
  logic [7:0]  wr_addr0, wr_addr1;
  logic [23:0] wr_data0, wr_data1;
  logic        busy, done, err;

  poly_mau_wb dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .base0(base0), .base1(base1), .in_valid(in_valid),
    .in_o0(in_o0), .in_o1(in_o1), .hold(hold), .wr_en(wr_en),
    .wr_ready(wr_ready), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [23:0] d0;
    logic [23:0] d1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_got, mon_exp;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wr_total = 0;
  int   done_cnt = 0;
  int   last_wr_cyc = 0;
  int   sent = 0;
  int   first_hold = -1;

  logic [23:0] da0 [4] = '{24'hA0A0A0, 24'hB0B0B0, 24'hC0C0C0, 24'hD0D0D0};
  logic [23:0] da1 [4] = '{24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C, 24'h0D0D0D};
  logic [7:0]  t1a0 [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
  logic [7:0]  t1a1 [4] = '{8'h90, 8'h91, 8'h92, 8'h93};
  logic [7:0]  t4a0 [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  logic [7:0]  t4a1 [4] = '{8'h7E, 8'h7F, 8'h80, 8'h81};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every write the DUT performs must match the head of the queue.
  always @(negedge clk) begin
    if (wr_en && wr_ready) begin
      mon_got = {wr_addr0, wr_addr1, wr_data0, wr_data1};
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h required=none", mon_got);
      end else begin
        mon_exp = sb.pop_front();
        check("write", mon_got, mon_exp);
      end
      wr_total++;
      last_wr_cyc = cyc;
    end
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [23:0] d0, input logic [23:0] d1,
                      input logic [7:0] a0, input logic [7:0] a1);
    in_valid = 1'b1;
    in_o0    = d0;
    in_o1    = d1;
    sb.push_back({a0, a1, d0, d1});
  endtask

  task automatic start_job(input logic [8:0] l, input logic [7:0] b0, input logic [7:0] b1);
    start = 1'b1;
    len   = l;
    base0 = b0;
    base1 = b1;
    step();
    start = 1'b0;
  endtask

  // Upstream that obeys hold: issues pair 'sent' only when hold is low.
  task automatic feed(input int iters, input int total, input logic [7:0] b0,
                      input logic [7:0] b1, input logic [23:0] dbase);
    for (int i = 0; i < iters; i++) begin
      if (sent >= total) break;
      if (!hold) begin
        send(24'(dbase + 24'(sent)), 24'(~dbase + 24'(sent)),
             8'(b0 + 8'(sent)), 8'(b1 + 8'(sent)));
        sent++;
      end else begin
        in_valid = 1'b0;
        if (first_hold < 0) first_hold = sent;
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hold"},  64'(hold),     64'd1);
    check({tag, "_wr_en"}, 64'(wr_en),    64'd0);
    check({tag, "_addr0"}, 64'(wr_addr0), 64'd0);
    check({tag, "_addr1"}, 64'(wr_addr1), 64'd0);
    check({tag, "_data0"}, 64'(wr_data0), 64'd0);
    check({tag, "_data1"}, 64'(wr_data1), 64'd0);
    check({tag, "_busy"},  64'(busy),     64'd0);
    check({tag, "_done"},  64'(done),     64'd0);
    check({tag, "_err"},   64'(err),      64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_wr;
    int dc;
    rst_n = 1'b0; start = 1'b0; len = '0; base0 = '0; base1 = '0;
    in_valid = 1'b0; in_o0 = '0; in_o1 = '0; wr_ready = 1'b1;
    #3;
    check_reset_outputs("rst");
    step(); step();
    rst_n = 1'b1;
    step();
    check("idle_busy", 64'(busy), 64'd0);

    // Job 1: four back-to-back pairs, RAM always ready
    start_job(9'd4, 8'h10, 8'h90);
    check("t1_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 4; k++) begin
      send(da0[k], da1[k], t1a0[k], t1a1[k]);
      step();
    end
    in_valid = 1'b0;
    wait_done("t1_done");
    check("t1_done_latency", 64'(cyc), 64'(last_wr_cyc + 1));
    check("t1_err", 64'(err), 64'd0);
    check("t1_all_written", 64'(sb.size()), 64'd0);
    step();
    check("t1_done_one_cycle", 64'(done), 64'd0);
    check("t1_idle", 64'(busy), 64'd0);

    // Job 2: RAM stalled for 10 cycles, upstream obeys hold
    wr_ready = 1'b0;
    start_job(9'd8, 8'h20, 8'hA0);
    sent = 0;
    first_hold = -1;
    feed(10, 8, 8'h20, 8'hA0, 24'h200000);
    check("t2_hold_level", 64'(first_hold), 64'd2);
    check("t2_hold_high", 64'(hold), 64'd1);
    wr_ready = 1'b1;
    feed(100, 8, 8'h20, 8'hA0, 24'h200000);
    check("t2_sent", 64'(sent), 64'd8);
    wait_done("t2_done");
    check("t2_err", 64'(err), 64'd0);
    check("t2_all_written", 64'(sb.size()), 64'd0);
    step();

    // Job 3: overfill the FIFO while RAM is stalled
    wr_ready = 1'b0;
    start_job(9'd8, 8'h30, 8'hB0);
    for (int k = 0; k < 4; k++) begin
      send(24'(24'h300000 + 24'(k)), 24'(~24'h300000 + 24'(k)),
           8'(8'h30 + 8'(k)), 8'(8'hB0 + 8'(k)));
      step();
    end
    check("t3_full_no_err", 64'(err), 64'd0);
    in_valid = 1'b1;
    in_o0 = 24'hEEEEEE;
    in_o1 = 24'hEEEEEE;
    step();
    in_valid = 1'b0;
    check("t3_drop_err", 64'(err), 64'd1);
    wr_ready = 1'b1;
    sent = 4;
    feed(100, 8, 8'h30, 8'hB0, 24'h300000);
    wait_done("t3_done");
    check("t3_err_sticky", 64'(err), 64'd1);
    check("t3_all_written", 64'(sb.size()), 64'd0);
    step();

    // Job 4: address wrap; a start issued mid-job must be ignored
    start_job(9'd4, 8'hFE, 8'h7E);
    check("t4_err_cleared", 64'(err), 64'd0);
    send(da0[0], da1[0], t4a0[0], t4a1[0]);
    start = 1'b1;
    len   = 9'd0;
    base0 = 8'h00;
    step();
    start = 1'b0;
    check("t4_start_ignored_busy", 64'(busy), 64'd1);
    check("t4_start_ignored_done", 64'(done), 64'd0);
    for (int k = 1; k < 4; k++) begin
      send(da0[k], da1[k], t4a0[k], t4a1[k]);
      step();
    end
    in_valid = 1'b0;
    wait_done("t4_done");
    check("t4_all_written", 64'(sb.size()), 64'd0);
    step();

    // Job 5: zero-length job
    start_job(9'd0, 8'h55, 8'h55);
    check("t5_done", 64'(done), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_wr_en", 64'(wr_en), 64'd0);
    step();
    check("t5_done_cleared", 64'(done), 64'd0);
    check("t5_idle_hold", 64'(hold), 64'd1);

    // Job 6: reset after three of six writes
    start_job(9'd6, 8'h40, 8'hC0);
    base_wr = wr_total;
    dc = done_cnt;
    for (int k = 0; k < 6; k++) begin
      send(24'(24'h400000 + 24'(k)), 24'(24'h4F0000 + 24'(k)),
           8'(8'h40 + 8'(k)), 8'(8'hC0 + 8'(k)));
      step();
      if (wr_total - base_wr == 3) break;
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t6_writes_before_reset", 64'(wr_total - base_wr), 64'd3);
    check_reset_outputs("t6_rst");
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
    check("t6_idle_busy", 64'(busy), 64'd0);
    check("t6_idle_hold", 64'(hold), 64'd1);
    repeat (3) step();
    check("t6_no_done", 64'(done_cnt), 64'(dc));
    check("t6_no_writes", 64'(wr_total - base_wr), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_mau_wb.md
POLY_MAU_WB -- requirements
Module: poly_mau_wb

Interface
REQ-001 Parameter ADDR_W, default 8, coefficient RAM address width.
REQ-002 Parameter FIFO_DEPTH, default 4, result-pair FIFO entries (power of two, >=4).
REQ-003 Parameter INFLIGHT, default 2, results upstream can still emit after hold asserts.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle job launch; honoured only in IDLE.
REQ-007 len  input  ADDR_W+1  result pairs expected for the job, 0..2^ADDR_W.
REQ-008 base0 / base1  input  ADDR_W each  start write address, bank 0 / bank 1.
REQ-009 in_valid  input  1  poly_valid from the MAU stage.
REQ-010 in_o0 / in_o1  input  24 each  MAU result pair (poly_mau_o0 / poly_mau_o1).
REQ-011 hold  output  1  stall request to MAU issue logic.
REQ-012 wr_en  output  1  write request, both banks together.
REQ-013 wr_ready  input  1  RAM accepts the write this cycle.
REQ-014 wr_addr0 / wr_addr1  output  ADDR_W each  write addresses.
REQ-015 wr_data0 / wr_data1  output  24 each  write data.
REQ-016 busy  output  1  high in RUN and DRAIN.
REQ-017 done  output  1  one-cycle pulse at job completion.
REQ-018 err  output  1  sticky overflow/excess-result flag, cleared by accepted start.

Function
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; only one state active.
REQ-020 IDLE: start=1 latches len/base0/base1, clears acc_cnt, wr_cnt, FIFO, err; next state RUN (len>0) or DONE (len=0).
REQ-021 start outside IDLE is ignored, no state change.
REQ-022 RUN: push when in_valid=1 and acc_cnt<len; acc_cnt += 1 per push.
REQ-023 in_valid=1 with acc_cnt>=len, or in IDLE/DRAIN/DONE: data dropped, err set.
REQ-024 Push with FIFO full and no pop in same cycle: data dropped, err set, acc_cnt unchanged.
REQ-025 Simultaneous push and pop when full: both occur, no error, occupancy unchanged.
REQ-026 wr_en = FIFO non-empty in RUN or DRAIN; wr_data0/1 = FIFO head o0/o1 (combinational from head).
REQ-027 wr_addr0 = base0+wr_cnt, wr_addr1 = base1+wr_cnt, modulo 2^ADDR_W (wrap, no error).
REQ-028 Pop on wr_en&&wr_ready; wr_cnt += 1; wr_en held with stable addr/data while wr_ready=0.
REQ-029 RUN->DRAIN on the cycle acc_cnt reaches len (including via final push).
REQ-030 DRAIN->DONE when wr_cnt reaches len; DONE asserts done for one cycle, then IDLE.
REQ-031 hold = 1 when occupancy >= FIFO_DEPTH-INFLIGHT, or in DRAIN/DONE/IDLE; combinational from registered occupancy.
REQ-032 Order preserved: k-th accepted pair written to base+k.
REQ-033 Write latency: pair pushed in cycle t may be written earliest at t+1 (FIFO registered).

Reset
REQ-034 rst_n low asynchronously forces IDLE, empties FIFO, zeroes acc_cnt, wr_cnt, latched len/bases.
REQ-035 During reset: hold=1, wr_en=0, wr_addr0/1=0, wr_data0/1=0, busy=0, done=0, err=0.
REQ-036 Reset mid-job abandons it silently; no done pulse; first cycle after release is IDLE.

Verification
REQ-037 len=4, base0=0x10, base1=0x90, wr_ready=1, 4 back-to-back valids A..D -> writes (0x10,0x90)=A ... (0x13,0x93)=D, done one cycle after last write, err=0.
REQ-038 len=8, wr_ready=0 for 10 cycles, upstream obeys hold -> hold high at occupancy 2, no drops, all 8 written in order after wr_ready=1.
REQ-039 FIFO full, wr_ready=0, extra in_valid -> pair dropped, err=1, acc_cnt unchanged; err clears on next start.
REQ-040 base0=0xFE, len=4 -> wr_addr0 sequence 0xFE,0xFF,0x00,0x01.
REQ-041 len=0 start -> DONE next cycle, done pulse, no wr_en; start during RUN ignored.
REQ-042 rst_n low after 3 of 6 writes -> outputs reset values immediately, IDLE after release, no done.
